mem_stage_hs: RTL
=================

// Module: mem_stage_hs
// PURPOSE
//  Next-generation MEM pipeline stage between EXE and WB. Replaces the fixed-latency synchronous-SRAM access
//  with a req/addr_ok/data_ok handshake bus, so it tolerates any number of bus wait states.
//  Merges byte/half/word load extension and LWL/LWR partial-word merging into one parametrised path.
//  Buffers returned data while WB stalls, and supports a flush that correctly drains an in-flight access.
// PARAMETERS
//  DATA_W   32  datapath / bus data width (multiple of 8; byte-strobe width = DATA_W/8)
//  ADDR_W   32  virtual/physical address width
//  REGNUM_W 5   destination register number width
//  WTYPE_W  3   write_type forwarding tag width
// PORTS
//  clk                 in  1          clock
//  rst_n               in  1          reset, asynchronous, active-low
//  wb_allowin_in       in  1          WB can accept this cycle
//  mem_allowin_out     out 1          MEM can accept from EXE
//  exe_valid_in        in  1          EXE bundle valid
//  mem_valid_out       out 1          MEM bundle valid to WB
//  mem_flush_in        in  1          cancel the instruction held in MEM
//  exe_sel_wbdata_in   in  4          one-hot: 0 aluout, 1 ext-load, 2 lwl/lwr merge, 3 NNPC
//  exe_aluout_in       in  DATA_W     ALU result
//  exe_lsu_op_in       in  4          mem_pkg LSU op (NONE,LB,LBU,LH,LHU,LW,LWL,LWR,SB,SH,SW,SWL,SWR)
//  exe_dm_wdata_in     in  DATA_W     store data, already lane-aligned
//  exe_dm_we_in        in  DATA_W/8   store byte strobes
//  exe_VAddr_in        in  ADDR_W     virtual address
//  exe_rt_in           in  DATA_W     old rt value for LWL/LWR merge
//  exe_PC_in / exe_NNPC_in in ADDR_W  PC; PC+8 link value
//  exe_regnum_in       in  REGNUM_W   destination register
//  exe_write_type_in   in  WTYPE_W    forwarding tag
//  mem_wbdata_out      out DATA_W     writeback data
//  mem_reg_we_out      out DATA_W/8   writeback byte enables
//  mem_PC_out          out ADDR_W     PC
//  mem_wnum_out        out REGNUM_W   destination register
//  mem_write_type_out  out WTYPE_W    forwarding tag
//  data_req            out 1          bus request
//  data_wr             out 1          1 = store
//  data_wstrb          out DATA_W/8   store byte strobes
//  data_addr           out ADDR_W     physical address
//  data_wdata          out DATA_W     store data
//  data_addr_ok        in  1          request accepted
//  data_data_ok        in  1          response / read data valid
//  data_rdata          in  DATA_W     read data
// BEHAVIOUR
//  - Reset (async): all regs and outputs 0, FSM=IDLE, valid_r=0, so mem_allowin_out=1 out of reset.
//    Reset asserted mid-access abandons it; the bus agent is reset by the same rst_n.
//  - Capture: on allowin && exe_valid_in, latch every exe_* field and set valid_r. On allowin && !exe_valid_in,
//    clear valid_r. allowin = !valid_r || (ready && wb_allowin_in).
//  - Translation: PAddr = VAddr in 0x8000_0000..0xBFFF_FFFF ? {3'b000,VAddr[28:0]} : VAddr (mem_pkg::fixed_map).
//  - FSM: IDLE, REQ, WAIT, DONE, DRAIN.
//    IDLE -> REQ the cycle after capturing an lsu_op != NONE.
//    REQ: data_req=1, addr/wr/wstrb/wdata held stable; REQ -> WAIT on data_addr_ok.
//    WAIT -> DONE on data_data_ok; data_rdata is latched into rdata_buf.
//    DONE -> IDLE when the bundle leaves (wb_allowin_in), or -> REQ directly if a new mem op is captured that cycle.
//  - addr_ok and data_ok in the same cycle while in REQ: go to DONE and latch the data.
//  - ready = (lsu_op==NONE) || state==DONE. mem_valid_out = valid_r && ready && !mem_flush_in.
//  - Writeback data:
//    sel[0] gives aluout; sel[3] gives NNPC; both give full mem_reg_we_out.
//    sel[1] gives load extension of rdata_buf by VAddr[1:0] (LB/LBU/LH/LHU/LW), with full mem_reg_we_out.
//    sel[2] gives the LWL/LWR merge with exe_rt_in; mem_reg_we_out is the partial byte mask.
//    Otherwise mem_wbdata_out=0 and mem_reg_we_out=0.
//  - Misaligned accesses are EXE's responsibility (they arrive as lsu_op NONE).
//  - Flush:
//    in IDLE/DONE, valid_r clears next cycle.
//    in REQ before addr_ok, drop data_req and go to IDLE.
//    in REQ with addr_ok, or in WAIT, go to DRAIN.
//    DRAIN swallows exactly one data_ok and then goes to IDLE; allowin=0 during DRAIN.
//  - Never more than one outstanding bus transaction.
// STRUCTURE
//  - mem_pkg: LSU op encoding, sel_wbdata bit indices, FSM state enum, fixed_map() function.
//  - Sub-module mem_load_align(DATA_W): combinational ext-load + LWL/LWR merge + byte-enable generation.
//  - Stage regs, FSM and bus drive stay in this module.
// TESTING
//  1. ALU op, sel=0001, aluout=0x1234_5678, wb_allowin=1 -> mem_valid_out next cycle, wbdata 0x1234_5678, we=4'hF.
//  2. LB at VAddr 0x8000_0003, addr_ok after 2 cycles, data_ok after 3 more, rdata=0x80xx_xxxx
//     -> data_addr=0x0000_0003, wbdata=0xFFFF_FF80, valid only after data_ok.
//  3. SW at 0xA000_0010, wdata 0xDEAD_BEEF -> data_req/wr=1, wstrb=4'hF, addr=0x0000_0010 held until addr_ok; we=0.
//  4. LW data_ok while wb_allowin=0 for 4 cycles -> data buffered, wbdata stable, mem_allowin_out=0 until release.
//  5. Flush in WAIT, then data_ok 2 cycles later -> no mem_valid_out, allowin=0 until data_ok, next load unaffected.
//  6. LWL at VAddr[1:0]=1, rt=0x1122_3344, rdata=0xAABB_CCDD -> wbdata=0xCCDD_3344, we=4'b1100; assert rst_n mid-WAIT -> all outputs 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the handshake MEM stage: LSU op codes, writeback-select
// bit positions, FSM states and the fixed kseg0/kseg1 address map.
package mem_pkg;

  typedef enum logic [3:0] {
    LSU_NONE = 4'd0,
    LSU_LB   = 4'd1,
    LSU_LBU  = 4'd2,
    LSU_LH   = 4'd3,
    LSU_LHU  = 4'd4,
    LSU_LW   = 4'd5,
    LSU_LWL  = 4'd6,
    LSU_LWR  = 4'd7,
    LSU_SB   = 4'd8,
    LSU_SH   = 4'd9,
    LSU_SW   = 4'd10,
    LSU_SWL  = 4'd11,
    LSU_SWR  = 4'd12
  } lsu_op_e;

  localparam int SEL_ALU   = 0;
  localparam int SEL_LOAD  = 1;
  localparam int SEL_MERGE = 2;
  localparam int SEL_NNPC  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // kseg0/kseg1 (0x8000_0000..0xBFFF_FFFF) fold onto the low 512 MB
  function automatic logic [31:0] fixed_map(input logic [31:0] vaddr);
    logic [31:0] paddr;
    if (vaddr[31:30] == 2'b10) begin
      paddr = {3'b000, vaddr[28:0]};
    end else begin
      paddr = vaddr;
    end
    return paddr;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Combinational load path: sign/zero extension of the returned word and the
// little-endian LWL/LWR merge with the old rt value, plus its byte-enable mask.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]               rdata,
  input  logic [$clog2(DATA_W/8)-1:0]     off,
  input  logic [3:0]                      lsu_op,
  input  logic [DATA_W-1:0]               rt,
  output logic [DATA_W-1:0]               ext_data,
  output logic [DATA_W-1:0]               merge_data,
  output logic [DATA_W/8-1:0]             merge_we
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int SH_W  = OFF_W + 3;

  logic [SH_W-1:0]   sh_lo_s;
  logic [SH_W-1:0]   sh_hi_s;
  logic [DATA_W-1:0] shr_s;
  logic [DATA_W-1:0] src_s;
  logic [DATA_W-1:0] mask_bits_s;

  // LWL shifts left by (NB-1-off) bytes, which is ~off for a power-of-two lane count
  assign sh_lo_s = {off, 3'b000};
  assign sh_hi_s = {~off, 3'b000};
  assign shr_s   = rdata >> sh_lo_s;

  // Extension of the addressed byte/half for the plain loads
  always_comb begin
    ext_data = rdata;
    case (lsu_op)
      LSU_LB:  ext_data = {{(DATA_W-8){shr_s[7]}}, shr_s[7:0]};
      LSU_LBU: ext_data = {{(DATA_W-8){1'b0}}, shr_s[7:0]};
      LSU_LH:  ext_data = {{(DATA_W-16){shr_s[15]}}, shr_s[15:0]};
      LSU_LHU: ext_data = {{(DATA_W-16){1'b0}}, shr_s[15:0]};
      default: ext_data = rdata;
    endcase
  end

  // Partial-word merge: only the lanes covered by the mask come from memory
  always_comb begin
    merge_we    = {NB{1'b0}};
    src_s       = shr_s;
    mask_bits_s = {DATA_W{1'b0}};
    if (lsu_op == LSU_LWL) begin
      merge_we = {NB{1'b1}} << ~off;
      src_s    = rdata << sh_hi_s;
    end else if (lsu_op == LSU_LWR) begin
      merge_we = {NB{1'b1}} >> off;
      src_s    = shr_s;
    end else begin
      merge_we = {NB{1'b0}};
      src_s    = shr_s;
    end
    for (int i = 0; i < NB; i++) begin
      mask_bits_s[8*i +: 8] = {8{merge_we[i]}};
    end
    merge_data = (src_s & mask_bits_s) | (rt & ~mask_bits_s);
  end

endmodule

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage talking to a req/addr_ok/data_ok bus; holds one bundle,
// buffers read data while WB stalls and drains an in-flight access on flush.
module mem_stage_hs
  import mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REGNUM_W = 5,
  parameter int WTYPE_W  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_allowin_in,
  output logic                  mem_allowin_out,
  input  logic                  exe_valid_in,
  output logic                  mem_valid_out,
  input  logic                  mem_flush_in,
  input  logic [3:0]            exe_sel_wbdata_in,
  input  logic [DATA_W-1:0]     exe_aluout_in,
  input  logic [3:0]            exe_lsu_op_in,
  input  logic [DATA_W-1:0]     exe_dm_wdata_in,
  input  logic [DATA_W/8-1:0]   exe_dm_we_in,
  input  logic [ADDR_W-1:0]     exe_VAddr_in,
  input  logic [DATA_W-1:0]     exe_rt_in,
  input  logic [ADDR_W-1:0]     exe_PC_in,
  input  logic [ADDR_W-1:0]     exe_NNPC_in,
  input  logic [REGNUM_W-1:0]   exe_regnum_in,
  input  logic [WTYPE_W-1:0]    exe_write_type_in,
  output logic [DATA_W-1:0]     mem_wbdata_out,
  output logic [DATA_W/8-1:0]   mem_reg_we_out,
  output logic [ADDR_W-1:0]     mem_PC_out,
  output logic [REGNUM_W-1:0]   mem_wnum_out,
  output logic [WTYPE_W-1:0]    mem_write_type_out,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [DATA_W/8-1:0]   data_wstrb,
  output logic [ADDR_W-1:0]     data_addr,
  output logic [DATA_W-1:0]     data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic [DATA_W-1:0]     data_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  state_e                state_q, state_d;
  logic                  valid_q, valid_d;
  logic [3:0]            sel_q, sel_d;
  logic [3:0]            lsu_op_q, lsu_op_d;
  logic [DATA_W-1:0]     aluout_q, aluout_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NB-1:0]         we_q, we_d;
  logic [ADDR_W-1:0]     vaddr_q, vaddr_d;
  logic [DATA_W-1:0]     rt_q, rt_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [ADDR_W-1:0]     nnpc_q, nnpc_d;
  logic [REGNUM_W-1:0]   regnum_q, regnum_d;
  logic [WTYPE_W-1:0]    wtype_q, wtype_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;

  logic                  ready_s;
  logic                  allowin_s;
  logic                  capture_s;
  logic                  capture_mem_s;
  logic                  resp_s;
  logic [ADDR_W-1:0]     paddr_s;
  logic [DATA_W-1:0]     ext_data_s;
  logic [DATA_W-1:0]     merge_data_s;
  logic [NB-1:0]         merge_we_s;
  logic [DATA_W-1:0]     wb_s;
  logic [NB-1:0]         reg_we_s;

  // A flush blocks capture for its cycle; DRAIN blocks until the orphan response is gone
  assign ready_s       = (lsu_op_q == LSU_NONE) || (state_q == ST_DONE);
  assign allowin_s     = !mem_flush_in && (state_q != ST_DRAIN) &&
                         (!valid_q || (ready_s && wb_allowin_in));
  assign capture_s     = allowin_s && exe_valid_in;
  assign capture_mem_s = capture_s && (exe_lsu_op_in != LSU_NONE);
  assign resp_s        = ((state_q == ST_REQ) && data_addr_ok && data_data_ok) ||
                         ((state_q == ST_WAIT) && data_data_ok);

  generate
    if (ADDR_W == 32) begin : g_map
      assign paddr_s = fixed_map(vaddr_q);
    end else begin : g_nomap
      assign paddr_s = vaddr_q;
    end
  endgenerate

  mem_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata      (rdata_q),
    .off        (vaddr_q[OFF_W-1:0]),
    .lsu_op     (lsu_op_q),
    .rt         (rt_q),
    .ext_data   (ext_data_s),
    .merge_data (merge_data_s),
    .merge_we   (merge_we_s)
  );

  // Stage capture, read-data buffer and bus FSM next state
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    sel_d    = sel_q;
    lsu_op_d = lsu_op_q;
    aluout_d = aluout_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    vaddr_d  = vaddr_q;
    rt_d     = rt_q;
    pc_d     = pc_q;
    nnpc_d   = nnpc_q;
    regnum_d = regnum_q;
    wtype_d  = wtype_q;
    rdata_d  = resp_s ? data_rdata : rdata_q;

    if (capture_s) begin
      valid_d  = 1'b1;
      sel_d    = exe_sel_wbdata_in;
      lsu_op_d = exe_lsu_op_in;
      aluout_d = exe_aluout_in;
      wdata_d  = exe_dm_wdata_in;
      we_d     = exe_dm_we_in;
      vaddr_d  = exe_VAddr_in;
      rt_d     = exe_rt_in;
      pc_d     = exe_PC_in;
      nnpc_d   = exe_NNPC_in;
      regnum_d = exe_regnum_in;
      wtype_d  = exe_write_type_in;
    end else if (allowin_s || mem_flush_in) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end

    case (state_q)
      ST_IDLE: state_d = capture_mem_s ? ST_REQ : ST_IDLE;
      ST_REQ: begin
        // an accepted request whose data is not back yet must be drained
        if (mem_flush_in) begin
          state_d = (data_addr_ok && !data_data_ok) ? ST_DRAIN : ST_IDLE;
        end else if (data_addr_ok) begin
          state_d = data_data_ok ? ST_DONE : ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (data_data_ok) begin
          state_d = mem_flush_in ? ST_IDLE : ST_DONE;
        end else if (mem_flush_in) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (mem_flush_in) begin
          state_d = ST_IDLE;
        end else if (wb_allowin_in) begin
          state_d = capture_mem_s ? ST_REQ : ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DRAIN: state_d = data_data_ok ? ST_IDLE : ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Writeback data and byte-enable select
  always_comb begin
    wb_s     = {DATA_W{1'b0}};
    reg_we_s = {NB{1'b0}};
    if (sel_q[SEL_ALU]) begin
      wb_s     = aluout_q;
      reg_we_s = {NB{1'b1}};
    end else if (sel_q[SEL_NNPC]) begin
      wb_s     = DATA_W'(nnpc_q);
      reg_we_s = {NB{1'b1}};
    end else if (sel_q[SEL_LOAD]) begin
      wb_s     = ext_data_s;
      reg_we_s = {NB{1'b1}};
    end else if (sel_q[SEL_MERGE]) begin
      wb_s     = merge_data_s;
      reg_we_s = merge_we_s;
    end else begin
      wb_s     = {DATA_W{1'b0}};
      reg_we_s = {NB{1'b0}};
    end
  end

  // Stage and FSM registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      sel_q    <= 4'd0;
      lsu_op_q <= 4'd0;
      aluout_q <= {DATA_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      we_q     <= {NB{1'b0}};
      vaddr_q  <= {ADDR_W{1'b0}};
      rt_q     <= {DATA_W{1'b0}};
      pc_q     <= {ADDR_W{1'b0}};
      nnpc_q   <= {ADDR_W{1'b0}};
      regnum_q <= {REGNUM_W{1'b0}};
      wtype_q  <= {WTYPE_W{1'b0}};
      rdata_q  <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      lsu_op_q <= lsu_op_d;
      aluout_q <= aluout_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      vaddr_q  <= vaddr_d;
      rt_q     <= rt_d;
      pc_q     <= pc_d;
      nnpc_q   <= nnpc_d;
      regnum_q <= regnum_d;
      wtype_q  <= wtype_d;
      rdata_q  <= rdata_d;
    end
  end

  assign mem_allowin_out    = allowin_s;
  assign mem_valid_out      = valid_q && ready_s && !mem_flush_in;
  assign mem_wbdata_out     = wb_s;
  assign mem_reg_we_out     = reg_we_s;
  assign mem_PC_out         = pc_q;
  assign mem_wnum_out       = regnum_q;
  assign mem_write_type_out = wtype_q;
  assign data_req           = (state_q == ST_REQ);
  assign data_wr            = data_req && (lsu_op_q >= LSU_SB);
  assign data_wstrb         = we_q;
  assign data_addr          = paddr_s;
  assign data_wdata         = wdata_q;

endmodule
